// File: rtl/mult_stage_pkg.sv
// mult_stage_pkg: PE array geometry (PECfg) and multiplier-stage control types (PECtlCfg)
//   PECfg    : DWD (operand width), PSUMDWD (partial-sum width), PEROW (rows per PE)
//   PECtlCfg : TNUMWD, AuMode, MSctl, SSctl, FSpipeout, FSout, ms_state_e
package PECfg;
    localparam int DWD     = 16;
    localparam int PSUMDWD = 32;
    localparam int PEROW   = 4;
endpackage

package PECtlCfg;
    import PECfg::*;
    localparam int TNUMWD = 4;
    typedef enum logic [1:0] {XNOR = 2'd0, INT4 = 2'd1, INT8 = 2'd2, INT16 = 2'd3} AuMode;
    typedef struct packed {
        AuMode             mode;
        logic [TNUMWD-1:0] iNumT;
        logic [TNUMWD-1:0] wNumT;
        logic [PEROW-1:0]  AuMask;
    } MSctl;
    typedef logic [7:0] SSctl;
    typedef struct packed {
        MSctl msctl;
        SSctl ssctl;
    } FSpipeout;
    typedef struct packed {
        logic [DWD-1:0]     Input_FS;
        logic [DWD-1:0]     Weight_FS;
        logic [PSUMDWD-1:0] Psum_FS;
    } FSout;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} ms_state_e;
endpackage

// File: rtl/mult_stage_au_lane_mult.sv
// au_lane_mult: combinational per-row product for XNOR / INT4 / INT8 / INT16 modes
//   mode_i : AuMode selecting the lane packing
//   a_i    : DWD-bit input operand
//   b_i    : DWD-bit weight operand
//   prod_o : product sign-extended to PSUMDWD
module au_lane_mult
    import PECfg::*;
    import PECtlCfg::*;
(
    input  AuMode              mode_i,
    input  logic [DWD-1:0]     a_i,
    input  logic [DWD-1:0]     b_i,
    output logic [PSUMDWD-1:0] prod_o
);
    logic signed [PSUMDWD-1:0] x_s, i4_s, i8_s, i16_s;
    always_comb begin
        // binary dot product: each matching bit is +1, each differing bit -1
        x_s  = -PSUMDWD'(DWD);
        i4_s = '0;
        i8_s = '0;
        for (int k = 0; k < DWD; k++)
            x_s = x_s + {{(PSUMDWD-2){1'b0}}, ~(a_i[k] ^ b_i[k]), 1'b0};
        for (int k = 0; k < DWD/4; k++)
            i4_s = i4_s + PSUMDWD'($signed(a_i[4*k +: 4])) * PSUMDWD'($signed(b_i[4*k +: 4]));
        for (int k = 0; k < DWD/8; k++)
            i8_s = i8_s + PSUMDWD'($signed(a_i[8*k +: 8])) * PSUMDWD'($signed(b_i[8*k +: 8]));
    end
    assign i16_s  = PSUMDWD'($signed(a_i)) * PSUMDWD'($signed(b_i));
    assign prod_o = mode_i == XNOR ? x_s : mode_i == INT4 ? i4_s : mode_i == INT8 ? i8_s : i16_s;
endmodule

// File: rtl/mult_stage.sv
// mult_stage: accumulates iNumT+1 beats of per-row products into partial sums, then holds the result
//   i_clk, i_rst      : clock, synchronous active-low reset
//   FS_rdy / FS_ack   : upstream beat handshake
//   MS_rdy / MS_ack   : downstream result handshake
//   i_data            : per-row Input_FS, Weight_FS, Psum_FS
//   i_MSpipe_FS       : msctl + ssctl, sampled on the first beat of a result
//   o_data            : accumulated partial sums, valid while MS_rdy
//   o_MSpipe_MS       : ssctl latched from the first beat
//   Optional macro MS_SAT_EN: saturating accumulate instead of wrapping
module mult_stage
    import PECfg::*;
    import PECtlCfg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          FS_rdy,
    output logic                          FS_ack,
    output logic                          MS_rdy,
    input  logic                          MS_ack,
    input  FSout [PEROW-1:0]              i_data,
    input  FSpipeout                      i_MSpipe_FS,
    output logic [PEROW-1:0][PSUMDWD-1:0] o_data,
    output SSctl                          o_MSpipe_MS
);
    function automatic logic [PSUMDWD-1:0] psum_add(input logic [PSUMDWD-1:0] a, input logic [PSUMDWD-1:0] b);
        logic [PSUMDWD-1:0] s;
        s = a + b;
`ifdef MS_SAT_EN
        return (a[PSUMDWD-1] == b[PSUMDWD-1] && s[PSUMDWD-1] != a[PSUMDWD-1]) ?
               {a[PSUMDWD-1], {(PSUMDWD-1){~a[PSUMDWD-1]}}} : s;
`else
        return s;
`endif
    endfunction

    ms_state_e                     state_q, state_d;
    logic [TNUMWD-1:0]             cnt_q, cnt_d;
    logic [PEROW-1:0][PSUMDWD-1:0] acc_q, acc_d;
    AuMode                         mode_q, mode_d, lane_mode;
    SSctl                          ss_q, ss_d;
    logic [PEROW-1:0][PSUMDWD-1:0] prod;
    // weight-tile count and row mask belong to other stages
    logic                          unused_ctl;

    assign unused_ctl = ^{i_MSpipe_FS.msctl.wNumT, i_MSpipe_FS.msctl.AuMask};
    // the first beat multiplies with its own mode; later beats use the latched one
    assign lane_mode  = state_q == IDLE ? i_MSpipe_FS.msctl.mode : mode_q;

    for (genvar g = 0; g < PEROW; g++) begin : g_lane
        au_lane_mult u_mult (
            .mode_i (lane_mode),
            .a_i    (i_data[g].Input_FS),
            .b_i    (i_data[g].Weight_FS),
            .prod_o (prod[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        ss_d    = ss_q;
        unique case (state_q)
            IDLE: if (FS_rdy) begin
                for (int i = 0; i < PEROW; i++) acc_d[i] = psum_add(i_data[i].Psum_FS, prod[i]);
                mode_d  = i_MSpipe_FS.msctl.mode;
                ss_d    = i_MSpipe_FS.ssctl;
                cnt_d   = i_MSpipe_FS.msctl.iNumT;
                state_d = i_MSpipe_FS.msctl.iNumT == '0 ? OUT : ACC;
            end
            ACC: if (FS_rdy) begin
                for (int i = 0; i < PEROW; i++) acc_d[i] = psum_add(acc_q[i], prod[i]);
                cnt_d   = cnt_q - TNUMWD'(1);
                state_d = cnt_q == TNUMWD'(1) ? OUT : ACC;
            end
            OUT: state_d = MS_ack ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mode_q  <= XNOR;
            ss_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            ss_q    <= ss_d;
        end
    end

    assign FS_ack      = state_q != OUT;
    assign MS_rdy      = state_q == OUT;
    assign o_data      = acc_q;
    assign o_MSpipe_MS = ss_q;
endmodule

// File: tb/tb_mult_stage.sv
// tb_mult_stage: directed self-checking bench for mult_stage
module tb_mult_stage;
    import PECfg::*;
    import PECtlCfg::*;

    logic i_clk = 1'b0, i_rst = 1'b0, FS_rdy = 1'b0, MS_ack = 1'b0;
    logic FS_ack, MS_rdy;
    FSout [PEROW-1:0] i_data;
    FSpipeout i_MSpipe_FS;
    logic [PEROW-1:0][PSUMDWD-1:0] o_data;
    SSctl o_MSpipe_MS;
    int n_cmp = 0, n_err = 0;

    always #5 i_clk = ~i_clk;

    mult_stage dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .FS_rdy      (FS_rdy),
        .FS_ack      (FS_ack),
        .MS_rdy      (MS_rdy),
        .MS_ack      (MS_ack),
        .i_data      (i_data),
        .i_MSpipe_FS (i_MSpipe_FS),
        .o_data      (o_data),
        .o_MSpipe_MS (o_MSpipe_MS)
    );

    task automatic set_in(input AuMode m, input logic [TNUMWD-1:0] n, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] p, input logic [31:0] step, input SSctl s);
        i_MSpipe_FS.msctl.mode   = m;
        i_MSpipe_FS.msctl.iNumT  = n;
        i_MSpipe_FS.msctl.wNumT  = ~n;
        i_MSpipe_FS.msctl.AuMask = '1;
        i_MSpipe_FS.ssctl        = s;
        for (int r = 0; r < PEROW; r++) begin
            i_data[r].Input_FS  = a;
            i_data[r].Weight_FS = b;
            i_data[r].Psum_FS   = p + step * 32'(r);
        end
    endtask

    task automatic beat0(input AuMode m, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p, input SSctl s);
        set_in(m, 0, a, b, p, 0, s);
        FS_rdy = 1'b1;
        @(negedge i_clk);
        FS_rdy = 1'b0;
    endtask

    task automatic ack_out();
        MS_ack = 1'b1;
        @(negedge i_clk);
        MS_ack = 1'b0;
    endtask

    task automatic test_reset();
        set_in(INT16, 0, 16'h1234, 16'h5678, 32'h1, 0, 8'h5A);
        FS_rdy = 1'b1;
        i_rst  = 1'b0;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (MS_rdy !== 1'b0) begin n_err++; $display("FAIL reset_ms_rdy: got %b want 0", MS_rdy); end
        n_cmp++; if (o_MSpipe_MS !== 8'h00) begin n_err++; $display("FAIL reset_ss: got %h want 00", o_MSpipe_MS); end
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'h0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", r, o_data[r]); end
        end
        i_rst  = 1'b1;
        FS_rdy = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (FS_ack !== 1'b1) begin n_err++; $display("FAIL reset_fs_ack: got %b want 1", FS_ack); end
        n_cmp++; if (MS_rdy !== 1'b0) begin n_err++; $display("FAIL reset_idle_ms_rdy: got %b want 0", MS_rdy); end
    endtask

    task automatic test_int16();
        set_in(INT16, 0, 16'd3, 16'hFFFB, 32'd100, 1, 8'hA5);
        FS_rdy = 1'b1;
        @(negedge i_clk);
        FS_rdy = 1'b0;
        n_cmp++; if (MS_rdy !== 1'b1) begin n_err++; $display("FAIL int16_ms_rdy: got %b want 1", MS_rdy); end
        n_cmp++; if (FS_ack !== 1'b0) begin n_err++; $display("FAIL int16_fs_ack: got %b want 0", FS_ack); end
        n_cmp++; if (o_MSpipe_MS !== 8'hA5) begin n_err++; $display("FAIL int16_ss: got %h want a5", o_MSpipe_MS); end
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd85 + 32'(r)) begin n_err++; $display("FAIL int16_data[%0d]: got %0d want %0d", r, $signed(o_data[r]), 85 + r); end
        end
        ack_out();
        n_cmp++; if (MS_rdy !== 1'b0 || FS_ack !== 1'b1) begin n_err++; $display("FAIL int16_idle: got rdy=%b ack=%b want 0 1", MS_rdy, FS_ack); end
    endtask

    task automatic test_int4();
        set_in(INT4, 2, 16'h1111, 16'h2222, 32'd0, 0, 8'h3C);
        FS_rdy = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (MS_rdy !== 1'b0) begin n_err++; $display("FAIL int4_beat1_rdy: got %b want 0", MS_rdy); end
        // later beats carry misleading control and psum which must be ignored
        set_in(XNOR, 0, 16'h1111, 16'h2222, 32'h0000DEAD, 3, 8'hFF);
        @(negedge i_clk);
        n_cmp++; if (MS_rdy !== 1'b0) begin n_err++; $display("FAIL int4_beat2_rdy: got %b want 0", MS_rdy); end
        FS_rdy = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            n_cmp++; if (MS_rdy !== 1'b0 || FS_ack !== 1'b1) begin n_err++; $display("FAIL int4_hold: got rdy=%b ack=%b want 0 1", MS_rdy, FS_ack); end
        end
        FS_rdy = 1'b1;
        @(negedge i_clk);
        FS_rdy = 1'b0;
        n_cmp++; if (MS_rdy !== 1'b1) begin n_err++; $display("FAIL int4_out_rdy: got %b want 1", MS_rdy); end
        n_cmp++; if (o_MSpipe_MS !== 8'h3C) begin n_err++; $display("FAIL int4_ss: got %h want 3c", o_MSpipe_MS); end
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd24) begin n_err++; $display("FAIL int4_data[%0d]: got %0d want 24", r, $signed(o_data[r])); end
        end
        ack_out();
        beat0(INT4, 16'h8888, 16'h8888, 32'd0, 8'h01);
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd256) begin n_err++; $display("FAIL int4_neg[%0d]: got %0d want 256", r, $signed(o_data[r])); end
        end
        ack_out();
    endtask

    task automatic test_xnor_int8();
        beat0(XNOR, 16'hFFFF, 16'h00FF, 32'd0, 8'h02);
        n_cmp++; if (o_data[0] !== 32'd0) begin n_err++; $display("FAIL xnor_half: got %0d want 0", $signed(o_data[0])); end
        ack_out();
        beat0(XNOR, 16'hFFFF, 16'hFFFF, 32'd0, 8'h03);
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd16) begin n_err++; $display("FAIL xnor_full[%0d]: got %0d want 16", r, $signed(o_data[r])); end
        end
        ack_out();
        beat0(XNOR, 16'h0000, 16'hFFFF, 32'd0, 8'h04);
        n_cmp++; if (o_data[1] !== 32'hFFFFFFF0) begin n_err++; $display("FAIL xnor_none: got %0d want -16", $signed(o_data[1])); end
        ack_out();
        beat0(INT8, 16'h0302, 16'h04FF, 32'd5, 8'h05);
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd15) begin n_err++; $display("FAIL int8_data[%0d]: got %0d want 15", r, $signed(o_data[r])); end
        end
        ack_out();
    endtask

    task automatic test_back_to_back();
        beat0(INT16, 16'd7, 16'd6, 32'd0, 8'h11);
        set_in(INT16, 0, 16'd1, 16'd1, 32'h100, 0, 8'h22);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (FS_ack !== 1'b0 || MS_rdy !== 1'b1) begin n_err++; $display("FAIL bp_handshake[%0d]: got ack=%b rdy=%b want 0 1", i, FS_ack, MS_rdy); end
            n_cmp++; if (o_data[2] !== 32'd42 || o_MSpipe_MS !== 8'h11) begin n_err++; $display("FAIL bp_stable[%0d]: got %0d/%h want 42/11", i, $signed(o_data[2]), o_MSpipe_MS); end
            FS_rdy = (i % 2 == 0);
            @(negedge i_clk);
        end
        FS_rdy = 1'b0;
        ack_out();
        n_cmp++; if (FS_ack !== 1'b1 || MS_rdy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got ack=%b rdy=%b want 1 0", FS_ack, MS_rdy); end
        beat0(INT16, 16'd2, 16'd2, 32'd1, 8'h33);
        n_cmp++; if (MS_rdy !== 1'b1 || o_data[3] !== 32'd5) begin n_err++; $display("FAIL b2b_data: got rdy=%b %0d want 1 5", MS_rdy, $signed(o_data[3])); end
        ack_out();
    endtask

    task automatic test_reset_mid();
        set_in(INT16, 2, 16'd100, 16'd100, 32'd1000, 0, 8'h44);
        FS_rdy = 1'b1;
        @(negedge i_clk);
        FS_rdy = 1'b0;
        i_rst  = 1'b0;
        @(negedge i_clk);
        i_rst  = 1'b1;
        n_cmp++; if (MS_rdy !== 1'b0 || o_data[0] !== 32'd0) begin n_err++; $display("FAIL rst_acc_clear: got rdy=%b %0d want 0 0", MS_rdy, $signed(o_data[0])); end
        beat0(INT16, 16'd2, 16'd3, 32'd1, 8'h55);
        n_cmp++; if (MS_rdy !== 1'b1) begin n_err++; $display("FAIL rst_fresh_rdy: got %b want 1", MS_rdy); end
        for (int r = 0; r < PEROW; r++) begin
            n_cmp++; if (o_data[r] !== 32'd7) begin n_err++; $display("FAIL rst_fresh_data[%0d]: got %0d want 7", r, $signed(o_data[r])); end
        end
        n_cmp++; if (o_MSpipe_MS !== 8'h55) begin n_err++; $display("FAIL rst_fresh_ss: got %h want 55", o_MSpipe_MS); end
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        n_cmp++; if (MS_rdy !== 1'b0 || FS_ack !== 1'b1) begin n_err++; $display("FAIL rst_out_drop: got rdy=%b ack=%b want 0 1", MS_rdy, FS_ack); end
    endtask

    task automatic test_sat();
        logic [31:0] e_hi, e_lo;
`ifdef MS_SAT_EN
        e_hi = 32'h7FFFFFFF;
        e_lo = 32'h80000000;
`else
        e_hi = 32'h80000000;
        e_lo = 32'h7FFFFFFF;
`endif
        beat0(INT16, 16'd1, 16'd1, 32'h7FFFFFFF, 8'h66);
        n_cmp++; if (o_data[0] !== e_hi) begin n_err++; $display("FAIL sat_pos: got %h want %h", o_data[0], e_hi); end
        ack_out();
        beat0(INT16, 16'd1, 16'hFFFF, 32'h80000000, 8'h77);
        n_cmp++; if (o_data[1] !== e_lo) begin n_err++; $display("FAIL sat_neg: got %h want %h", o_data[1], e_lo); end
        ack_out();
    endtask

    initial begin
        set_in(XNOR, 0, 16'h0, 16'h0, 32'h0, 0, 8'h0);
        test_reset();
        test_int16();
        test_int4();
        test_xnor_int8();
        test_back_to_back();
        test_reset_mid();
        test_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
